imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Byte-stream program loader; the write side of the instruction memory.
- Receives a length-prefixed little-endian image over a valid/ready byte interface and assembles 32-bit words.
- Issues single-cycle word writes into instruction memory, then releases the core via cpu_run.
- Sits between the host link (UART/debug byte source) and the instruction memory write port.

Parameters:
- DEPTH, 1024, instruction memory capacity in 32-bit words; longest legal image.
- BASE_ADDR, 32'h00000000, byte address of the first word written; must be word-aligned.
- CNT_W, 11, width of the word counters; must hold DEPTH.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  one-cycle pulse; begins a load
- in_valid  input  1  byte source has data
- in_data  input  8  byte from source
- in_ready  output  1  loader accepts a byte this cycle
- mem_we  output  1  instruction memory write strobe, one cycle per word
- mem_addr  output  32  byte address of the write, word-aligned (the memory indexes with address[31:2])
- mem_wdata  output  32  word to write
- busy  output  1  load in progress
- done  output  1  last load completed successfully
- error  output  1  last load failed
- cpu_run  output  1  core may fetch; low during and before a load
- words_loaded  output  CNT_W  words written in the current or last load

Behaviour:
- Reset asynchronously forces state IDLE, all counters 0, and all outputs 0, including cpu_run.
  - A partially assembled word is discarded.
  - Memory contents are not cleared.
- A byte transfers only when in_valid && in_ready on a rising edge.
- Bytes are little-endian: the first byte is bits [7:0].
- IDLE:
  - in_ready=0.
  - start → LEN; clear the byte counter, length and words_loaded; busy=1; done, error and cpu_run drop to 0.
- LEN:
  - in_ready=1; accept 4 bytes into len[31:0].
  - After the 4th byte: len==0 → DONE; len>DEPTH → ERR; otherwise → DATA.
- DATA:
  - in_ready=1; accept 4 bytes into the word buffer.
  - After the 4th byte → WRITE.
- WRITE:
  - in_ready=0 and mem_we=1 for exactly one cycle, the cycle after the 4th byte is accepted.
  - mem_addr = BASE_ADDR + (words_loaded<<2); mem_wdata = assembled word.
  - words_loaded increments at the end of the cycle.
  - If the new count equals len → DONE (or CHK when the feature is enabled); else → DATA.
- DONE:
  - busy=0, done=1, cpu_run=1, all held.
  - start → LEN, as from IDLE.
- ERR:
  - busy=0, error=1 (sticky), cpu_run=0.
  - start → LEN.
- start while busy is ignored.
- mem_we=0, mem_addr=0 and mem_wdata=0 in every state other than WRITE.
- The address is never written beyond BASE_ADDR + ((DEPTH-1)<<2), because len is bounded before any write.
- Bytes offered while in_ready=0 are not consumed; the source holds them.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - After the last WRITE, enter CHK with in_ready=1 and accept 4 checksum bytes.
  - Compare against the running sum mod 2^32 of all written data words.
  - Match → DONE; mismatch → ERR (cpu_run stays 0).
  - len==0 also goes through CHK with an expected sum of 0.
- Undefined: no CHK state and no accumulator; the stream ends at the last data word.

Test Plan:
- Two-word load:
  - Stimulus: reset, start, bytes 02 00 00 00, 93 00 50 00, 13 01 10 00.
  - Required: mem_we pulses with (0x0, 0x00500093) and (0x4, 0x00100113); then done=1, cpu_run=1, words_loaded=2, error=0.
- Zero length: start, bytes 00 00 00 00 → no mem_we; done=1 and cpu_run=1 one cycle after the 4th byte.
- Oversize: start, bytes 01 04 00 00 (len=1025) → error=1, cpu_run=0, no mem_we; a subsequent start plus a valid stream → done=1, error=0.
- Backpressure and gaps: repeat the two-word load with in_valid toggling every other cycle and held high during WRITE.
  - Required: identical writes with no lost or duplicated byte; in_ready=0 in the WRITE cycle.
- Reset mid-load: assert reset after 6 bytes accepted → all outputs 0 immediately; deassert, start, full two-word stream → correct writes, done=1.
- Checksum (IMEM_LOADER_CHECKSUM_EN defined): len=1, word 78 56 34 12.
  - Checksum bytes 78 56 34 12 → done=1.
  - Checksum bytes 00 00 00 00 → error=1, cpu_run=0.

Source files
------------

// File: rtl/imem_loader.sv
// Byte-stream program loader: length-prefixed little-endian image in, 32-bit instruction memory writes out.
// Optional trailing checksum word is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          CNT_W     = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic             cpu_run,
  output logic [CNT_W-1:0] words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_DATA, S_WRITE, S_DONE, S_ERR
`ifdef IMEM_LOADER_CHECKSUM_EN
    , S_CHK
`endif
  } state_t;

  localparam logic [31:0] DEPTH_L = 32'(DEPTH);

  state_t           state;
  logic [1:0]       bcnt;
  logic [31:0]      len;
  logic [23:0]      shreg;
  logic             acc;
  logic             last_byte;
  logic [31:0]      word_full;
  logic [CNT_W-1:0] wl_next;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0]      sum;
`endif

  assign acc       = in_valid & in_ready;
  assign last_byte = (bcnt == 2'd3);
  // The incoming byte lands on top; earlier bytes have shifted toward bit 0.
  assign word_full = {in_data, shreg};
  assign wl_next   = words_loaded + CNT_W'(1);

  // Byte assembly is pure data; a stale partial word is harmless once bcnt is cleared.
  always_ff @(posedge clk) begin
    if (acc) shreg <= word_full[31:8];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      bcnt         <= 2'd0;
      len          <= 32'd0;
      in_ready     <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= 32'd0;
      mem_wdata    <= 32'd0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      cpu_run      <= 1'b0;
      words_loaded <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum          <= 32'd0;
`endif
    end else begin
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      if (acc) bcnt <= bcnt + 2'd1;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state        <= S_LEN;
            bcnt         <= 2'd0;
            len          <= 32'd0;
            words_loaded <= '0;
            in_ready     <= 1'b1;
            busy         <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            cpu_run      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum          <= 32'd0;
`endif
          end
        end
        S_LEN: begin
          if (acc && last_byte) begin
            len <= word_full;
            if (word_full == 32'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state    <= S_CHK;
`else
              state    <= S_DONE;
              in_ready <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              cpu_run  <= 1'b1;
`endif
            end else if (word_full > DEPTH_L) begin
              state    <= S_ERR;
              in_ready <= 1'b0;
              busy     <= 1'b0;
              error    <= 1'b1;
            end else begin
              state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (acc && last_byte) begin
            state     <= S_WRITE;
            in_ready  <= 1'b0;
            mem_we    <= 1'b1;
            mem_addr  <= BASE_ADDR + 32'({words_loaded, 2'b00});
            mem_wdata <= word_full;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum       <= sum + word_full;
`endif
          end
        end
        S_WRITE: begin
          words_loaded <= wl_next;
          in_ready     <= 1'b1;
          if (32'(wl_next) == len) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state    <= S_CHK;
`else
            state    <= S_DONE;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
            cpu_run  <= 1'b1;
`endif
          end else begin
            state <= S_DATA;
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHK: begin
          if (acc && last_byte) begin
            in_ready <= 1'b0;
            busy     <= 1'b0;
            if (word_full == sum) begin
              state   <= S_DONE;
              done    <= 1'b1;
              cpu_run <= 1'b1;
            end else begin
              state <= S_ERR;
              error <= 1'b1;
            end
          end
        end
`endif
        default: begin
          state    <= S_IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a stream-level model predicts writes and final status, a monitor checks every cycle.
module tb_imem_loader;

  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          CNT_W = 11;

  typedef logic [7:0] byte_q_t[$];

  logic             clk = 1'b0;
  logic             reset, start, in_valid;
  logic [7:0]       in_data;
  logic             in_ready, mem_we, busy, done, error, cpu_run;
  logic [31:0]      mem_addr, mem_wdata;
  logic [CNT_W-1:0] words_loaded;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  logic [31:0] cap_addr[$];
  logic [31:0] cap_data[$];
  logic        exp_done, exp_err, exp_run;
  int          exp_wl;

  imem_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .error(error), .cpu_run(cpu_run), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Stream-level model: decode the image and predict writes and final status.
  task automatic model(input byte_q_t b);
    logic [31:0] len, w, sum;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] cks;
    int          c;
`endif
    len = {b[3], b[2], b[1], b[0]};
    exp_done = 1'b0; exp_err = 1'b0; exp_wl = 0; sum = 32'd0;
    if (len > 32'(DEPTH)) begin
      exp_err = 1'b1;
    end else begin
      for (int k = 0; k < int'(len); k++) begin
        w = {b[4*k+7], b[4*k+6], b[4*k+5], b[4*k+4]};
        exp_addr.push_back(BASE + 32'(4*k));
        exp_data.push_back(w);
        sum = sum + w;
      end
      exp_wl = int'(len);
`ifdef IMEM_LOADER_CHECKSUM_EN
      c = 4 + 4*int'(len);
      cks = {b[c+3], b[c+2], b[c+1], b[c]};
      if (cks == sum) exp_done = 1'b1; else exp_err = 1'b1;
`else
      exp_done = 1'b1;
`endif
    end
    exp_run = exp_done;
  endtask

  // Per-cycle monitor: every write must match the next predicted write.
  always @(negedge clk) begin
    if (!reset) begin
      if (mem_we) begin
        cap_addr.push_back(mem_addr);
        cap_data.push_back(mem_wdata);
        chk("in_ready low in write", in_ready, 1'b0);
        if (exp_addr.size() == 0) begin
          chk("unexpected write", 1'b1, 1'b0);
        end else begin
          chk("write addr", mem_addr, exp_addr.pop_front());
          chk("write data", mem_wdata, exp_data.pop_front());
        end
      end else begin
        chk("idle addr zero", mem_addr, 32'd0);
        chk("idle data zero", mem_wdata, 32'd0);
      end
    end
  end

  task automatic do_start();
    cap_addr.delete();
    cap_data.delete();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input byte_q_t b, input bit gaps);
    int budget;
    for (int i = 0; i < b.size(); i++) begin
      if (gaps && (i % 2 == 0)) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = b[i];
      budget   = 0;
      forever begin
        @(negedge clk);
        if (in_ready) break;
        budget++;
        if (budget > 50) break;
      end
      if (budget > 50) begin
        chk("byte accept timeout", 1'b1, 1'b0);
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int budget = 0;
    while (busy && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    chk("load finish timeout", busy, 1'b0);
  endtask

  task automatic check_final(input string tag);
    chk({tag, " done"}, done, exp_done);
    chk({tag, " error"}, error, exp_err);
    chk({tag, " cpu_run"}, cpu_run, exp_run);
    chk({tag, " words_loaded"}, 32'(words_loaded), 32'(exp_wl));
    chk({tag, " pending writes"}, 32'(exp_addr.size()), 32'd0);
  endtask

  task automatic check_two_word_caps(input string tag);
    chk({tag, " write count"}, 32'(cap_addr.size()), 32'd2);
    if (cap_addr.size() == 2) begin
      chk({tag, " w0 addr"}, cap_addr[0], 32'h0000_0000);
      chk({tag, " w0 data"}, cap_data[0], 32'h0050_0093);
      chk({tag, " w1 addr"}, cap_addr[1], 32'h0000_0004);
      chk({tag, " w1 data"}, cap_data[1], 32'h0010_0113);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " in_ready"}, in_ready, 1'b0);
    chk({tag, " mem_we"}, mem_we, 1'b0);
    chk({tag, " mem_addr"}, mem_addr, 32'd0);
    chk({tag, " mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, " busy"}, busy, 1'b0);
    chk({tag, " done"}, done, 1'b0);
    chk({tag, " error"}, error, 1'b0);
    chk({tag, " cpu_run"}, cpu_run, 1'b0);
    chk({tag, " words_loaded"}, 32'(words_loaded), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    byte_q_t two, zero, over, part;
    two  = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00};
    zero = '{8'h00, 8'h00, 8'h00, 8'h00};
    over = '{8'h01, 8'h04, 8'h00, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
    // 0x00500093 + 0x00100113 = 0x006001A6
    two.push_back(8'hA6); two.push_back(8'h01); two.push_back(8'h60); two.push_back(8'h00);
    for (int i = 0; i < 4; i++) zero.push_back(8'h00);
`endif
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    // Two-word load
    model(two);
    chk("model w0 data", exp_data[0], 32'h0050_0093);
    chk("model w1 addr", exp_addr[1], 32'h0000_0004);
    do_start();
    chk("start busy", busy, 1'b1);
    chk("start in_ready", in_ready, 1'b1);
    send(two, 1'b0);
    wait_idle();
    check_final("two-word");
    check_two_word_caps("two-word");
    chk("two-word done literal", done, 1'b1);
    chk("two-word words literal", 32'(words_loaded), 32'd2);

    // Zero length: done the cycle after the last byte
    model(zero);
    do_start();
    send(zero, 1'b0);
    chk("zero-len done timing", done, 1'b1);
    wait_idle();
    check_final("zero-len");
    chk("zero-len no writes", 32'(cap_addr.size()), 32'd0);

    // Oversize image, then recovery
    model(over);
    chk("model oversize err", exp_err, 1'b1);
    do_start();
    send(over, 1'b0);
    wait_idle();
    check_final("oversize");
    chk("oversize no writes", 32'(cap_addr.size()), 32'd0);
    chk("oversize in_ready", in_ready, 1'b0);
    model(two);
    do_start();
    send(two, 1'b0);
    wait_idle();
    check_final("recover");
    check_two_word_caps("recover");

    // Gaps and backpressure, with a start pulse mid-load that must be ignored
    model(two);
    do_start();
    send(two[0:3], 1'b1);
    do_start();
    chk("start while busy", busy, 1'b1);
    send(two[4:$], 1'b1);
    wait_idle();
    check_final("gaps");
    check_two_word_caps("gaps");

    // Reset mid-load after six bytes
    model(two);
    do_start();
    part = two[0:5];
    send(part, 1'b0);
    reset = 1'b1;
    #1;
    check_all_zero("mid reset");
    exp_addr.delete();
    exp_data.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    model(two);
    do_start();
    send(two, 1'b0);
    wait_idle();
    check_final("after reset");
    check_two_word_caps("after reset");

`ifdef IMEM_LOADER_CHECKSUM_EN
    begin
      byte_q_t good, bad;
      good = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h78, 8'h56, 8'h34, 8'h12};
      bad  = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h00, 8'h00, 8'h00, 8'h00};
      model(good);
      do_start();
      send(good, 1'b0);
      wait_idle();
      check_final("cks good");
      chk("cks good done literal", done, 1'b1);
      model(bad);
      do_start();
      send(bad, 1'b0);
      wait_idle();
      check_final("cks bad");
      chk("cks bad error literal", error, 1'b1);
      chk("cks bad cpu_run literal", cpu_run, 1'b0);
    end
`endif

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
